axi_apb_bridge_mc: RTL

- Parametrised AXI4-slave to APB3 bridge with NUM_SLAVES decoded APB ports.
- Successor to the single-PSEL X2P path: adds per-slave address decode, a PREADY timeout, burst rejection and read/write round-robin.
- Sits between the interconnect's X2P master port and the peripheral APB slaves (CRC slave and future peripherals).

---
 rtl/axi_apb_bridge_mc_if.sv | 65 ++++++
 rtl/axi_apb_bridge_mc.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/axi_apb_bridge_mc_if.sv
// AXI4-slave / APB3-master signal bundle for axi_apb_bridge_mc.
// Defining X2P_APB4_EN adds the APB4 protection and strobe signals.
interface axi_apb_bridge_mc_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 5,
    parameter int NUM_SLAVES = 4
);
    logic                          aw_valid, aw_ready;
    logic [ADDR_WIDTH-1:0]         aw_addr;
    logic [ID_WIDTH-1:0]           aw_id;
    logic [7:0]                    aw_len;
    logic                          w_valid, w_ready, w_last;
    logic [DATA_WIDTH-1:0]         w_data;
    logic [DATA_WIDTH/8-1:0]       w_strb;
    logic                          b_valid, b_ready;
    logic [ID_WIDTH-1:0]           b_id;
    logic [1:0]                    b_resp;
    logic                          ar_valid, ar_ready;
    logic [ADDR_WIDTH-1:0]         ar_addr;
    logic [ID_WIDTH-1:0]           ar_id;
    logic [7:0]                    ar_len;
    logic                          r_valid, r_ready, r_last;
    logic [DATA_WIDTH-1:0]         r_data;
    logic [ID_WIDTH-1:0]           r_id;
    logic [1:0]                    r_resp;
    logic [NUM_SLAVES-1:0]         o_psel;
    logic                          o_penable, o_pwrite;
    logic [ADDR_WIDTH-1:0]         o_paddr;
    logic [DATA_WIDTH-1:0]         o_pwdata;
    logic [NUM_SLAVES*DATA_WIDTH-1:0] i_prdata;
    logic [NUM_SLAVES-1:0]         i_pready, i_pslverr;
`ifdef X2P_APB4_EN
    logic [2:0]                    aw_prot, ar_prot, o_pprot;
    logic [DATA_WIDTH/8-1:0]       o_pstrb;
`endif

    modport slave (
`ifdef X2P_APB4_EN
        input  aw_prot, ar_prot,
        output o_pprot, o_pstrb,
`endif
        input  aw_valid, aw_addr, aw_id, aw_len,
        input  w_valid, w_data, w_strb, w_last,
        input  b_ready, ar_valid, ar_addr, ar_id, ar_len, r_ready,
        input  i_prdata, i_pready, i_pslverr,
        output aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready,
        output r_valid, r_data, r_id, r_resp, r_last,
        output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata
    );

    modport master (
`ifdef X2P_APB4_EN
        output aw_prot, ar_prot,
        input  o_pprot, o_pstrb,
`endif
        output aw_valid, aw_addr, aw_id, aw_len,
        output w_valid, w_data, w_strb, w_last,
        output b_ready, ar_valid, ar_addr, ar_id, ar_len, r_ready,
        output i_prdata, i_pready, i_pslverr,
        input  aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready,
        input  r_valid, r_data, r_id, r_resp, r_last,
        input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata
    );
endinterface

// File: rtl/axi_apb_bridge_mc.sv
// AXI4-slave to APB3 bridge with per-slave decode, PREADY timeout, burst rejection
// and read/write round-robin. Define X2P_APB4_EN for APB4 pstrb/pprot outputs.
module axi_apb_bridge_mc #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int ID_WIDTH        = 5,
    parameter int NUM_SLAVES      = 4,
    parameter int SLAVE_ADDR_BITS = 12,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input logic                i_clk,
    input logic                i_rst,
    axi_apb_bridge_mc_if.slave bus
);
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int WIN_W  = ADDR_WIDTH - SLAVE_ADDR_BITS;
    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WDRAIN, RESP} state_e;

    state_e                state_q, state_d;
    logic                  isWrite_q, isWrite_d;
    logic                  rrWrite_q, rrWrite_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            beats_q, beats_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [1:0]            resp_q, resp_d;
    logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
`ifdef X2P_APB4_EN
    logic [DATA_WIDTH/8-1:0] strb_q, strb_d;
    logic [2:0]              prot_q, prot_d;
`endif

    logic                  grantW, grantR, reqHit;
    logic [ADDR_WIDTH-1:0] reqAddr;
    logic [7:0]            reqLen;
    logic                  selReady, selErr;
    logic [DATA_WIDTH-1:0] selData;

    // Requests are only granted from IDLE; reset holds all ready outputs low.
    always_comb begin
        grantW  = (state_q == IDLE) && !i_rst && bus.aw_valid && bus.w_valid
                  && (!bus.ar_valid || rrWrite_q);
        grantR  = (state_q == IDLE) && !i_rst && bus.ar_valid && !grantW;
        reqAddr = grantW ? bus.aw_addr : bus.ar_addr;
        reqLen  = grantW ? bus.aw_len : bus.ar_len;
        reqHit  = reqAddr[ADDR_WIDTH-1:SLAVE_ADDR_BITS] < WIN_W'(NUM_SLAVES);
    end

    always_comb begin
        selReady = 1'b0;
        selErr   = 1'b0;
        selData  = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                selReady = bus.i_pready[k];
                selErr   = bus.i_pslverr[k];
                selData  = bus.i_prdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        isWrite_d = isWrite_q;
        rrWrite_d = rrWrite_q;
        id_d      = id_q;
        beats_d   = beats_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        idx_d     = idx_q;
        resp_d    = resp_q;
        tcnt_d    = tcnt_q;
`ifdef X2P_APB4_EN
        strb_d    = strb_q;
        prot_d    = prot_q;
`endif
        case (state_q)
            IDLE: begin
                if (grantW || grantR) begin
                    isWrite_d = grantW;
                    rrWrite_d = grantR;
                    id_d      = grantW ? bus.aw_id : bus.ar_id;
                    addr_d    = reqAddr;
                    idx_d     = reqAddr[SLAVE_ADDR_BITS +: IDX_W];
                    beats_d   = grantW ? 8'd0 : reqLen;
                    rdata_d   = '0;
                    tcnt_d    = '0;
                    if (grantW) wdata_d = bus.w_data;
`ifdef X2P_APB4_EN
                    strb_d    = grantW ? bus.w_strb : '0;
                    prot_d    = grantW ? bus.aw_prot : bus.ar_prot;
`endif
                    // Bursts are rejected before decode so every W beat is still drained.
                    if (reqLen != 8'd0) begin
                        resp_d  = RESP_SLVERR;
                        state_d = (grantW && !bus.w_last) ? WDRAIN : RESP;
                    end else if (!reqHit) begin
                        resp_d  = RESP_DECERR;
                        state_d = RESP;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (selReady) begin
                    resp_d  = selErr ? RESP_SLVERR : RESP_OKAY;
                    if (!isWrite_q) rdata_d = selData;
                    state_d = RESP;
                end else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
                    resp_d  = RESP_SLVERR;
                    state_d = RESP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            WDRAIN: if (bus.w_valid && bus.w_last) state_d = RESP;
            RESP: begin
                if (isWrite_q ? bus.b_ready : bus.r_ready) begin
                    if (!isWrite_q && beats_q != 8'd0) beats_d = beats_q - 8'd1;
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            isWrite_q <= 1'b0;
            rrWrite_q <= 1'b1;
            id_q      <= '0;
            beats_q   <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            idx_q     <= '0;
            resp_q    <= '0;
            tcnt_q    <= '0;
`ifdef X2P_APB4_EN
            strb_q    <= '0;
            prot_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            isWrite_q <= isWrite_d;
            rrWrite_q <= rrWrite_d;
            id_q      <= id_d;
            beats_q   <= beats_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            idx_q     <= idx_d;
            resp_q    <= resp_d;
            tcnt_q    <= tcnt_d;
`ifdef X2P_APB4_EN
            strb_q    <= strb_d;
            prot_q    <= prot_d;
`endif
        end
    end

    assign bus.aw_ready  = grantW;
    assign bus.w_ready   = grantW || (state_q == WDRAIN);
    assign bus.ar_ready  = grantR;
    assign bus.o_psel    = (state_q == SETUP || state_q == ACCESS)
                           ? (NUM_SLAVES'(1) << idx_q) : '0;
    assign bus.o_penable = (state_q == ACCESS);
    assign bus.o_pwrite  = isWrite_q;
    assign bus.o_paddr   = addr_q;
    assign bus.o_pwdata  = wdata_q;
    assign bus.b_valid   = (state_q == RESP) && isWrite_q;
    assign bus.b_id      = id_q;
    assign bus.b_resp    = resp_q;
    assign bus.r_valid   = (state_q == RESP) && !isWrite_q;
    assign bus.r_data    = rdata_q;
    assign bus.r_id      = id_q;
    assign bus.r_resp    = resp_q;
    assign bus.r_last    = bus.r_valid && (beats_q == 8'd0);
`ifdef X2P_APB4_EN
    assign bus.o_pstrb   = strb_q;
    assign bus.o_pprot   = prot_q;
`endif
endmodule
